// File: rtl/nlprg_n_pkg.sv
// rtl/nlprg_n_pkg.sv - shared limits and default primitive feedback masks for nlprg_n
package nlprg_n_pkg;

  localparam int NLPRG_N_MIN = 3;
  localparam int NLPRG_N_MAX = 32;

  // Bit i set => state bit i feeds the XOR; every mask is a primitive polynomial.
  function automatic logic [31:0] nlprg_taps(input int n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/nlprg_next.sv
// rtl/nlprg_next.sv - combinational next-state of the zero-spliced Fibonacci LFSR
module nlprg_next
  import nlprg_n_pkg::*;
#(
  parameter int             N    = 5,
  parameter logic [N-1:0]   TAPS = N'(nlprg_taps(N))
) (
  input  logic [N-1:0] s,
  output logic [N-1:0] nxt
);

  logic fb;

  // The low-bits-zero term splices 0 in between 100..0 and 00..01.
  assign fb  = (^(s & TAPS)) ^ (s[N-2:0] == '0);
  assign nxt = {s[N-2:0], fb};

endmodule

// File: rtl/nlprg_n.sv
// rtl/nlprg_n.sv - full-period pseudo-random generator with seed load, stream stepping and period self-check
module nlprg_n
  import nlprg_n_pkg::*;
#(
  parameter int             N    = 5,
  parameter logic [N-1:0]   TAPS = N'(nlprg_taps(N))
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [N-1:0] seed,
  input  logic         rdy,
  output logic [N-1:0] o,
  output logic         vld,
  output logic [N-1:0] cnt,
  output logic         wrap,
  output logic         err
);

  if (N < NLPRG_N_MIN || N > NLPRG_N_MAX || TAPS[N-1] != 1'b1) begin : g_bad_cfg
    $error("nlprg_n: N must be 3..32 and TAPS[N-1] must be set");
  end

  logic [N-1:0] state;
  logic [N-1:0] anchor;
  logic [N-1:0] nxt;

  nlprg_next #(.N(N), .TAPS(TAPS)) u_next (
    .s   (state),
    .nxt (nxt)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state  <= '0;
      anchor <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      vld  <= 1'b1;
      wrap <= 1'b0;
      if (ld) begin
        state  <= seed;
        anchor <= seed;
        cnt    <= '0;
      end else if (vld && rdy) begin
        state <= nxt;
        // Returning to the anchor must coincide with exactly 2^N accepted steps.
        if (nxt == anchor) begin
          wrap <= 1'b1;
          cnt  <= '0;
          if (cnt != '1) err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign o = state;

endmodule

// File: tb/tb_nlprg_n.sv
// tb/tb_nlprg_n.sv - directed self-checking bench for nlprg_n
module tb_nlprg_n;
  import nlprg_n_pkg::*;

  localparam logic [31:0] T8 = nlprg_taps(8);

  logic       ck = 1'b0;
  logic       rst_n;
  logic       ld;
  logic       rdy;
  logic [4:0] seed;

  logic [4:0] o_a, cnt_a;
  logic       vld_a, wrap_a, err_a;
  logic [4:0] o_b, cnt_b;
  logic       vld_b, wrap_b, err_b;
  logic [7:0] o_c, cnt_c;
  logic       vld_c, wrap_c, err_c;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  nlprg_n u_a (
    .ck(ck), .rst_n(rst_n), .ld(ld), .seed(seed), .rdy(rdy),
    .o(o_a), .vld(vld_a), .cnt(cnt_a), .wrap(wrap_a), .err(err_a)
  );

  nlprg_n #(.N(5), .TAPS(5'b11000)) u_b (
    .ck(ck), .rst_n(rst_n), .ld(ld), .seed(seed), .rdy(rdy),
    .o(o_b), .vld(vld_b), .cnt(cnt_b), .wrap(wrap_b), .err(err_b)
  );

  nlprg_n #(.N(8), .TAPS(T8[7:0])) u_c (
    .ck(ck), .rst_n(rst_n), .ld(ld), .seed({3'b000, seed}), .rdy(rdy),
    .o(o_c), .vld(vld_c), .cnt(cnt_c), .wrap(wrap_c), .err(err_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    logic [4:0]  exp1 [7];
    logic [31:0] seen;
    int          k;
    int          early;

    exp1  = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd9, 5'd18, 5'd5};
    seen  = '0;
    rst_n = 1'b0;
    ld    = 1'b0;
    rdy   = 1'b1;
    seed  = '0;

    #12;
    chk("rst_o",    32'(o_a),    0);
    chk("rst_vld",  32'(vld_a),  0);
    chk("rst_cnt",  32'(cnt_a),  0);
    chk("rst_wrap", 32'(wrap_a), 0);
    chk("rst_err",  32'(err_a),  0);
    @(negedge ck);
    rst_n = 1'b1;

    // 1. first words after reset
    step();
    chk("t1_vld", 32'(vld_a), 1);
    chk("t1_o0",  32'(o_a),   32'(exp1[0]));
    seen[o_a] = 1'b1;
    for (int i = 1; i < 7; i++) begin
      step();
      chk("t1_seq", 32'(o_a), 32'(exp1[i]));
      seen[o_a] = 1'b1;
    end
    chk("t1_cnt", 32'(cnt_a), 6);

    // 2. full period from reset
    early = 0;
    for (int i = 7; i < 32; i++) begin
      step();
      seen[o_a] = 1'b1;
      if (wrap_a) early++;
    end
    step();
    chk("t2_o",     32'(o_a),    0);
    chk("t2_wrap",  32'(wrap_a), 1);
    chk("t2_cnt",   32'(cnt_a),  0);
    chk("t2_err",   32'(err_a),  0);
    chk("t2_seen",  seen,        32'hFFFF_FFFF);
    chk("t2_early", 32'(early),  0);
    step();
    chk("t2_wrap1", 32'(wrap_a), 0);
    chk("t2_o1",    32'(o_a),    1);
    chk("t2_cnt1",  32'(cnt_a),  1);

    // 3. consumer stalls
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_o",    32'(o_a),    1);
      chk("t3_cnt",  32'(cnt_a),  1);
      chk("t3_vld",  32'(vld_a),  1);
      chk("t3_wrap", 32'(wrap_a), 0);
    end
    rdy = 1'b1;

    // 4. seed load and period from the seed
    ld   = 1'b1;
    seed = 5'b10101;
    step();
    ld = 1'b0;
    chk("t4_o",    32'(o_a),    32'h15);
    chk("t4_cnt",  32'(cnt_a),  0);
    chk("t4_wrap", 32'(wrap_a), 0);
    early = 0;
    for (int i = 1; i < 32; i++) begin
      step();
      if (wrap_a) early++;
    end
    step();
    chk("t4_wrap32", 32'(wrap_a), 1);
    chk("t4_o32",    32'(o_a),    32'h15);
    chk("t4_cnt32",  32'(cnt_a),  0);
    chk("t4_err",    32'(err_a),  0);
    chk("t4_early",  32'(early),  0);
    for (int i = 1; i < 32; i++) step();
    chk("t4_cnt31", 32'(cnt_a), 31);
    ld   = 1'b1;
    seed = 5'b00011;
    step();
    ld = 1'b0;
    chk("t4_ldwrap", 32'(wrap_a), 0);
    chk("t4_ldo",    32'(o_a),    3);
    chk("t4_ldcnt",  32'(cnt_a),  0);
    chk("t4_lderr",  32'(err_a),  0);
    step();
    chk("t4_ldwrap1", 32'(wrap_a), 0);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("ar_o",   32'(o_a),   0);
    chk("ar_vld", 32'(vld_a), 0);
    chk("ar_cnt", 32'(cnt_a), 0);
    @(negedge ck);
    rst_n = 1'b1;

    // 5. non-primitive taps: short period flagged, err sticky across ld
    step();
    k = 0;
    while (k < 40 && !wrap_b) begin
      step();
      k++;
    end
    chk("t5_period", 32'(k),     22);
    chk("t5_err",    32'(err_b), 1);
    chk("t5_o",      32'(o_b),   0);
    ld   = 1'b1;
    seed = 5'b00001;
    step();
    ld = 1'b0;
    chk("t5_ld_err", 32'(err_b), 1);
    chk("t5_ld_o",   32'(o_b),   1);
    chk("t5_ld_cnt", 32'(cnt_b), 0);
    step();
    chk("t5_err_hold", 32'(err_b), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_err", 32'(err_b), 0);
    chk("t5_rst_vld", 32'(vld_b), 0);
    @(negedge ck);
    rst_n = 1'b1;

    // 6. N=8 with default primitive mask
    step();
    chk("t6_o0",   32'(o_c),   0);
    chk("t6_vld0", 32'(vld_c), 1);
    k = 0;
    while (k < 300 && !wrap_c) begin
      step();
      k++;
    end
    chk("t6_period", 32'(k),     256);
    chk("t6_err",    32'(err_c), 0);
    chk("t6_cnt",    32'(cnt_c), 0);
    chk("t6_o",      32'(o_c),   0);
    for (int i = 0; i < 10; i++) step();
    chk("t6_cnt10", 32'(cnt_c), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ar_o",   32'(o_c),   0);
    chk("t6_ar_vld", 32'(vld_c), 0);
    chk("t6_ar_cnt", 32'(cnt_c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
